// File: rtl/sev_seg_scanner.sv
// rtl/sev_seg_scanner.sv - time-multiplexed common-anode seven-segment scanner
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   en            : scan enable; low freezes counters and turns the display off
//   load          : capture digits_in / dp_in / blink_mask into shadow registers
//   digits_in     : nibble i at [4i+3:4i], digit 0 is the rightmost digit
//   dp_in         : per-digit decimal point request, active-high
//   blink_mask    : per-digit blink enable
//   blank_lz      : leading-zero blanking enable (live, not shadowed)
//   an_out        : anode enables, active-low
//   seg_out       : segments {a,b,c,d,e,f,g} at [6:0], active-low
//   dp_out        : decimal point, active-low
//   scan_idx      : index of the digit owning the current slot
module sev_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 64,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [IDX_W-1:0]        scan_idx
);

  localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [RC_W-1:0]  RC_MAX  = RC_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(BLINK_DIV - 1);

  // Scan state
  logic [RC_W-1:0]  refresh_cnt_q, refresh_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  // Shadow registers
  logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]      blink_q, blink_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_out_q, dp_out_d;
  logic [IDX_W-1:0]      scan_idx_q;

  logic                  slot_end;
  logic                  scan_end;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  upper_zero;
  logic [3:0]            cur_nib;
  logic                  blink_on;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h01;
      4'h1: s = 7'h4F;
      4'h2: s = 7'h12;
      4'h3: s = 7'h06;
      4'h4: s = 7'h4C;
      4'h5: s = 7'h24;
      4'h6: s = 7'h20;
      4'h7: s = 7'h0F;
      4'h8: s = 7'h00;
      4'h9: s = 7'h04;
      4'hA: s = 7'h08;
      4'hB: s = 7'h60;
      4'hC: s = 7'h31;
      4'hD: s = 7'h42;
      4'hE: s = 7'h30;
      default: s = 7'h38;
    endcase
    return s;
  endfunction

  assign slot_end = (refresh_cnt_q == RC_MAX);
  assign scan_end = slot_end && (idx_q == IDX_MAX);

  // Counter and shadow next-state
  always_comb begin
    refresh_cnt_d = refresh_cnt_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    digits_d      = digits_q;
    dp_d          = dp_q;
    blink_d       = blink_q;

    if (en) begin
      refresh_cnt_d = slot_end ? '0 : refresh_cnt_q + 1'b1;
      if (slot_end) begin
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end
      // Blink time base counts completed scans, not cycles
      if (scan_end) begin
        if (blink_cnt_q == BC_MAX) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end

    if (load) begin
      digits_d = digits_in;
      dp_d     = dp_in;
      blink_d  = blink_mask;
    end
  end

  // A digit is a leading zero when it and every more-significant digit are zero.
  // Digit 0 always stays visible so a zero value still shows "0".
  always_comb begin
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (digits_q[i] == 4'h0);
      if (i != 0) begin
        lz_blank[i] = upper_zero;
      end
    end
  end

  assign cur_nib  = digits_q[idx_q];
  assign blink_on = blink_q[idx_q] & blink_phase_q;

  // Output next-state; segments stay decoded through the dead cycle, only the
  // anodes are forced off so the segment lines settle before the next digit lights.
  always_comb begin
    an_d     = '1;
    seg_d    = 7'h7F;
    dp_out_d = 1'b1;
    if (en) begin
      if (refresh_cnt_q != '0) begin
        an_d = ~(NUM_DIGITS'(1) << idx_q);
      end
      if (blink_on || (blank_lz && lz_blank[idx_q])) begin
        seg_d = 7'h7F;
      end else begin
        seg_d = seg_decode(cur_nib);
      end
      dp_out_d = blink_on ? 1'b1 : ~dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      digits_q      <= '0;
      dp_q          <= '0;
      blink_q       <= '0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_out_q      <= 1'b1;
      scan_idx_q    <= '0;
    end else begin
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      blink_q       <= blink_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_out_q      <= dp_out_d;
      scan_idx_q    <= idx_q;
    end
  end

  assign an_out   = an_q;
  assign seg_out  = seg_q;
  assign dp_out   = dp_out_q;
  assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_sev_seg_scanner.sv
// tb/tb_sev_seg_scanner.sv - self-checking bench for sev_seg_scanner
module tb_sev_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_mask = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  an_out;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [1:0]  scan_idx;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: count of enabled edges since reset plus shadow contents
  int          m_k;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  m_blk;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [1:0]  exp_idx;
  logic        seg_chk;

  logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                               7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

  sev_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blink_mask(blink_mask), .blank_lz(blank_lz),
    .an_out(an_out), .seg_out(seg_out), .dp_out(dp_out), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Predict the outputs produced by the coming edge, then advance the model and clock.
  task automatic tick();
    int rc, idx, ph, nib;
    logic blank, blinking;
    if (rst) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_idx = 2'd0; seg_chk = 1'b1;
      m_k = 0; m_dig = '0; m_dp = '0; m_blk = '0;
    end else begin
      rc  = m_k % RD;
      idx = (m_k / RD) % ND;
      ph  = (m_k / (RD * ND) / BD) % 2;
      nib = int'((m_dig >> (4 * idx)) & 16'hF);
      blank    = blank_lz && (idx >= 1) && ((m_dig >> (4 * idx)) == 16'h0);
      blinking = m_blk[idx] && (ph == 1);
      exp_idx = 2'(idx);
      if (!en) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; seg_chk = 1'b1;
      end else begin
        exp_an  = (rc == 0) ? 4'hF : ~(4'b0001 << idx);
        exp_seg = (blinking || blank) ? 7'h7F : seg_tab[nib];
        exp_dp  = blinking ? 1'b1 : ~m_dp[idx];
        seg_chk = (rc != 0);
      end
      if (en) m_k++;
      if (load) begin
        m_dig = digits_in; m_dp = dp_in; m_blk = blink_mask;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++; if (an_out !== 4'hF) begin tests_failed++; $display("FAIL reset an_out: got %h want f", an_out); end
      tests_run++; if (seg_out !== 7'h7F) begin tests_failed++; $display("FAIL reset seg_out: got %h want 7f", seg_out); end
      tests_run++; if (dp_out !== 1'b1) begin tests_failed++; $display("FAIL reset dp_out: got %b want 1", dp_out); end
      tests_run++; if (scan_idx !== 2'd0) begin tests_failed++; $display("FAIL reset scan_idx: got %0d want 0", scan_idx); end
    end
  endtask

  task automatic test_startup();
    logic [3:0] an_seq [20] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF, 4'hB,
                                4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF, 4'hE, 4'hE, 4'hE};
    logic [1:0] idx_seq [20] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0, 0, 0, 0};
    rst = 1'b0; en = 1'b1; blank_lz = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      tests_run++; if (an_out !== an_seq[c]) begin tests_failed++; $display("FAIL startup an_out cyc %0d: got %h want %h", c, an_out, an_seq[c]); end
      tests_run++; if (scan_idx !== idx_seq[c]) begin tests_failed++; $display("FAIL startup scan_idx cyc %0d: got %0d want %0d", c, scan_idx, idx_seq[c]); end
      if (an_out != 4'hF) begin
        tests_run++; if (seg_out !== 7'h01) begin tests_failed++; $display("FAIL startup seg_out cyc %0d: got %h want 01", c, seg_out); end
      end
    end
  endtask

  task automatic test_decode();
    logic [6:0] first [4]  = '{7'h06, 7'h12, 7'h4F, 7'h01};
    logic [6:0] second [4] = '{7'h60, 7'h08, 7'h04, 7'h00};
    blank_lz = 1'b0; dp_in = 4'h0; blink_mask = 4'h0;
    for (int pass = 0; pass < 2; pass++) begin
      digits_in = (pass == 0) ? 16'h0123 : 16'h89AB;
      load = 1'b1; tick(); load = 1'b0;
      for (int c = 0; c < 2 * RD * ND; c++) begin
        tick();
        tests_run++; if (an_out !== exp_an) begin tests_failed++; $display("FAIL decode an_out: got %h want %h", an_out, exp_an); end
        for (int d = 0; d < 4; d++) begin
          if (an_out == ~(4'b0001 << d)) begin
            tests_run++;
            if (seg_out !== ((pass == 0) ? first[d] : second[d])) begin
              tests_failed++;
              $display("FAIL decode seg_out digit %0d: got %h want %h", d, seg_out, (pass == 0) ? first[d] : second[d]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] want [2][4] = '{'{7'h01, 7'h24, 7'h7F, 7'h7F}, '{7'h01, 7'h7F, 7'h7F, 7'h7F}};
    blank_lz = 1'b1; dp_in = 4'h0; blink_mask = 4'h0;
    for (int pass = 0; pass < 2; pass++) begin
      digits_in = (pass == 0) ? 16'h0050 : 16'h0000;
      load = 1'b1; tick(); load = 1'b0;
      for (int c = 0; c < RD * ND; c++) begin
        tick();
        for (int d = 0; d < 4; d++) begin
          if (an_out == ~(4'b0001 << d)) begin
            tests_run++;
            if (seg_out !== want[pass][d]) begin
              tests_failed++;
              $display("FAIL lz seg_out digit %0d: got %h want %h", d, seg_out, want[pass][d]);
            end
          end
        end
        tests_run++; if (seg_chk && seg_out !== exp_seg) begin tests_failed++; $display("FAIL lz model seg_out: got %h want %h", seg_out, exp_seg); end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    int blanked, shown;
    blanked = 0; shown = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; blank_lz = 1'b0;
    digits_in = 16'($urandom); dp_in = 4'b0010; blink_mask = 4'b0010;
    load = 1'b1; tick(); load = 1'b0;
    for (int c = 0; c < 128; c++) begin
      tick();
      tests_run++; if (an_out !== exp_an) begin tests_failed++; $display("FAIL blink an_out: got %h want %h", an_out, exp_an); end
      if (seg_chk) begin
        tests_run++; if (seg_out !== exp_seg) begin tests_failed++; $display("FAIL blink seg_out: got %h want %h", seg_out, exp_seg); end
        tests_run++; if (dp_out !== exp_dp) begin tests_failed++; $display("FAIL blink dp_out: got %b want %b", dp_out, exp_dp); end
      end
      if (an_out == 4'hD) begin
        if (seg_out == 7'h7F && dp_out == 1'b1) blanked++;
        else if (dp_out == 1'b0) shown++;
      end
    end
    tests_run++; if (blanked != 12) begin tests_failed++; $display("FAIL blink off-count: got %0d want 12", blanked); end
    tests_run++; if (shown != 12) begin tests_failed++; $display("FAIL blink on-count: got %0d want 12", shown); end
    blink_mask = 4'h0;
  endtask

  task automatic test_enable_freeze();
    int guard;
    en = 1'b1; guard = 0;
    while ((m_k % RD) != 2 && guard < 64) begin tick(); guard++; end
    tests_run++; if (guard >= 64) begin tests_failed++; $display("FAIL freeze align: got %0d want <64", guard); end
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++; if (an_out !== 4'hF) begin tests_failed++; $display("FAIL freeze an_out: got %h want f", an_out); end
      tests_run++; if (seg_out !== 7'h7F) begin tests_failed++; $display("FAIL freeze seg_out: got %h want 7f", seg_out); end
      tests_run++; if (dp_out !== 1'b1) begin tests_failed++; $display("FAIL freeze dp_out: got %b want 1", dp_out); end
      tests_run++; if (scan_idx !== exp_idx) begin tests_failed++; $display("FAIL freeze scan_idx: got %0d want %0d", scan_idx, exp_idx); end
    end
    en = 1'b1;
    for (int c = 0; c < RD * ND; c++) begin
      tick();
      tests_run++; if (an_out !== exp_an) begin tests_failed++; $display("FAIL resume an_out: got %h want %h", an_out, exp_an); end
      tests_run++; if (scan_idx !== exp_idx) begin tests_failed++; $display("FAIL resume scan_idx: got %0d want %0d", scan_idx, exp_idx); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 7) == 0) || ((m_k % RD) == RD - 1 && $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      digits_in = 16'($urandom);
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 1) == 1) digits_in[4*i +: 4] = 4'h0;
      dp_in = 4'($urandom); blink_mask = 4'($urandom);
      tick();
      tests_run++; if (an_out !== exp_an) begin tests_failed++; $display("FAIL random an_out cyc %0d: got %h want %h", c, an_out, exp_an); end
      tests_run++; if (scan_idx !== exp_idx) begin tests_failed++; $display("FAIL random scan_idx cyc %0d: got %0d want %0d", c, scan_idx, exp_idx); end
      if (seg_chk) begin
        tests_run++; if (seg_out !== exp_seg) begin tests_failed++; $display("FAIL random seg_out cyc %0d: got %h want %h", c, seg_out, exp_seg); end
        tests_run++; if (dp_out !== exp_dp) begin tests_failed++; $display("FAIL random dp_out cyc %0d: got %b want %b", c, dp_out, exp_dp); end
      end
    end
    rst = 1'b0; load = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; blank_lz = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b1; load = 1'b1; digits_in = 16'hFFFF; dp_in = 4'hF; blink_mask = 4'hF;
    tick();
    rst = 1'b0; load = 1'b0;
    tests_run++; if (an_out !== 4'hF) begin tests_failed++; $display("FAIL rstmid an_out: got %h want f", an_out); end
    tests_run++; if (seg_out !== 7'h7F) begin tests_failed++; $display("FAIL rstmid seg_out: got %h want 7f", seg_out); end
    tests_run++; if (dp_out !== 1'b1) begin tests_failed++; $display("FAIL rstmid dp_out: got %b want 1", dp_out); end
    tests_run++; if (scan_idx !== 2'd0) begin tests_failed++; $display("FAIL rstmid scan_idx: got %0d want 0", scan_idx); end
    tick();
    tests_run++; if (an_out !== 4'hF) begin tests_failed++; $display("FAIL rstmid dead an_out: got %h want f", an_out); end
    tick();
    tests_run++; if (an_out !== 4'hE) begin tests_failed++; $display("FAIL rstmid lit an_out: got %h want e", an_out); end
    tests_run++; if (seg_out !== 7'h01) begin tests_failed++; $display("FAIL rstmid lit seg_out: got %h want 01", seg_out); end
    tests_run++; if (dp_out !== 1'b1) begin tests_failed++; $display("FAIL rstmid lit dp_out: got %b want 1", dp_out); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_decode();
    test_leading_zero();
    test_blink();
    test_enable_freeze();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
